// File: rtl/ldst_queue_pkg.sv
`default_nettype none
// ==========================================================================
// tomasula_types : shared entry layout, funct3 codes and FSM encoding for
//                  the load/store queue.                       Rev 1.0
// ==========================================================================
package tomasula_types;

   localparam int ROB_TAG_W = 3;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      REQ  = 1'b1
   } ldst_state_t;

   typedef struct packed {
      logic                 valid;
      logic                 is_store;
      logic                 committed;
      logic [2:0]           funct3;
      logic [31:0]          imm;
      logic [ROB_TAG_W-1:0] base_tag;
      logic [31:0]          base_data;
      logic                 base_valid;
      logic [ROB_TAG_W-1:0] sd_tag;
      logic [31:0]          sd_data;
      logic                 sd_valid;
      logic [ROB_TAG_W-1:0] rob_tag;
   } ldst_entry_t;

   // CDB slot i is addressed directly by the ROB tag that produced it.
   function automatic logic [31:0] cdb_word(input logic [8*32-1:0]      bus,
                                            input logic [ROB_TAG_W-1:0] tag);
      return bus[{tag, 5'b00000} +: 32];
   endfunction

endpackage
`default_nettype wire

// File: rtl/ldst_align.sv
`default_nettype none
// ==========================================================================
// ldst_align : byte-lane steering for stores and lane extract / extension
//              for loads.                                  Rev 1.0
// ==========================================================================
module ldst_align
   import tomasula_types::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] sd_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  mbe_o,
   output logic [31:0] ld_data_o
);

   logic [31:0] w_shift;

   assign w_shift = rdata_i >> {lane_i, 3'b000};

   always_comb begin
      wdata_o = sd_i;
      mbe_o   = 4'b1111;
      case (funct3_i)
         SB: begin
            wdata_o = {4{sd_i[7:0]}};
            mbe_o   = 4'b0001 << lane_i;
         end
         SH: begin
            wdata_o = {2{sd_i[15:0]}};
            mbe_o   = 4'b0011 << lane_i;
         end
         SW:      mbe_o = 4'b1111;
         default: mbe_o = 4'b1111;
      endcase
   end

   always_comb begin
      ld_data_o = w_shift;
      case (funct3_i)
         LB:      ld_data_o = {{24{w_shift[7]}}, w_shift[7:0]};
         LH:      ld_data_o = {{16{w_shift[15]}}, w_shift[15:0]};
         LBU:     ld_data_o = {24'h000000, w_shift[7:0]};
         LHU:     ld_data_o = {16'h0000, w_shift[15:0]};
         LW:      ld_data_o = w_shift;
         default: ld_data_o = w_shift;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/ldst_queue.sv
`default_nettype none
// ==========================================================================
// ldst_queue : in-order load/store queue with CDB snooping and a single
//              head-only memory handshake. Optional macro: LDSTQ_PERF_EN.
//              Rev 1.0
// ==========================================================================
module ldst_queue
   import tomasula_types::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = ROB_TAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             resldst_load,
   input  logic             in_is_store,
   input  logic [2:0]       in_funct3,
   input  logic [31:0]      in_imm,
   input  logic [TAG_W-1:0] in_base_tag,
   input  logic [31:0]      in_base_data,
   input  logic             in_base_valid,
   input  logic [TAG_W-1:0] in_sd_tag,
   input  logic [31:0]      in_sd_data,
   input  logic             in_sd_valid,
   input  logic [TAG_W-1:0] in_rob_tag,
   input  logic [8*32-1:0]  cdb_data,
   input  logic [7:0]       cdb_valid,
   input  logic             st_commit,
   input  logic [TAG_W-1:0] st_commit_tag,
   input  logic             branch_mispredict,
   output logic             ldst_q_full,
   output logic             data_read,
   output logic             data_write,
   output logic [31:0]      data_addr,
   output logic [31:0]      data_wdata,
   output logic [3:0]       data_mbe,
   input  logic             data_mem_resp,
   input  logic [31:0]      data_rdata,
   output logic             ld_done,
   output logic [TAG_W-1:0] ld_tag,
   output logic [31:0]      ld_data,
   output logic [15:0]      perf_loads,
   output logic [15:0]      perf_stores
);

   localparam int             PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

   ldst_entry_t      entry_q [DEPTH];
   ldst_entry_t      entry_d [DEPTH];
   ldst_entry_t      w_new;
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;
   ldst_state_t      state_q, state_d;
   logic             drop_q, drop_d;
   logic             ld_done_q;
   logic [TAG_W-1:0] ld_tag_q;
   logic [31:0]      ld_data_q;

   logic        w_in_req, w_go, w_commit_hit, w_enq, w_deq, w_report;
   logic [31:0] w_addr, w_wdata, w_ld_data;
   logic [3:0]  w_mbe;

   assign w_addr       = entry_q[head_q].base_data + entry_q[head_q].imm;
   assign w_in_req     = (state_q == REQ);
   assign w_commit_hit = st_commit && (st_commit_tag == entry_q[head_q].rob_tag);
   assign w_go         = entry_q[head_q].valid && entry_q[head_q].base_valid &&
                         (!entry_q[head_q].is_store ||
                          (entry_q[head_q].sd_valid &&
                           (entry_q[head_q].committed || w_commit_hit)));
   assign ldst_q_full  = (count_q == C_DEPTH);
   assign w_enq        = resldst_load && !ldst_q_full && !branch_mispredict;
   assign w_deq        = w_in_req && data_mem_resp;
   assign w_report     = w_deq && !drop_q && !branch_mispredict;

   ldst_align u_align (
      .funct3_i  (entry_q[head_q].funct3),
      .lane_i    (w_addr[1:0]),
      .sd_i      (entry_q[head_q].sd_data),
      .rdata_i   (data_rdata),
      .wdata_o   (w_wdata),
      .mbe_o     (w_mbe),
      .ld_data_o (w_ld_data)
   );

   // Operands already on the CDB during enqueue enter the queue as valid.
   always_comb begin
      w_new            = '0;
      w_new.valid      = 1'b1;
      w_new.is_store   = in_is_store;
      w_new.funct3     = in_funct3;
      w_new.imm        = in_imm;
      w_new.base_tag   = in_base_tag;
      w_new.sd_tag     = in_sd_tag;
      w_new.rob_tag    = in_rob_tag;
      w_new.base_data  = in_base_data;
      w_new.base_valid = in_base_valid;
      w_new.sd_data    = in_sd_data;
      w_new.sd_valid   = in_sd_valid;
      w_new.committed  = in_is_store && st_commit && (st_commit_tag == in_rob_tag);
      if (!in_base_valid && cdb_valid[in_base_tag]) begin
         w_new.base_data  = cdb_word(cdb_data, in_base_tag);
         w_new.base_valid = 1'b1;
      end
      if (!in_sd_valid && cdb_valid[in_sd_tag]) begin
         w_new.sd_data  = cdb_word(cdb_data, in_sd_tag);
         w_new.sd_valid = 1'b1;
      end
   end

   always_comb begin
      entry_d = entry_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_q[i].valid) begin
            if (!entry_q[i].base_valid && cdb_valid[entry_q[i].base_tag]) begin
               entry_d[i].base_data  = cdb_word(cdb_data, entry_q[i].base_tag);
               entry_d[i].base_valid = 1'b1;
            end
            if (!entry_q[i].sd_valid && cdb_valid[entry_q[i].sd_tag]) begin
               entry_d[i].sd_data  = cdb_word(cdb_data, entry_q[i].sd_tag);
               entry_d[i].sd_valid = 1'b1;
            end
            if (st_commit && entry_q[i].is_store && (entry_q[i].rob_tag == st_commit_tag))
               entry_d[i].committed = 1'b1;
         end
         if (branch_mispredict && !(w_in_req && (PTR_W'(i) == head_q)))
            entry_d[i].valid = 1'b0;
      end
      if (w_deq)
         entry_d[head_q].valid = 1'b0;
      if (w_enq)
         entry_d[tail_q] = w_new;
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      state_d = state_q;
      drop_d  = drop_q;
      if (w_deq)
         head_d = head_q + PTR_W'(1);
      if (w_enq)
         tail_d = tail_q + PTR_W'(1);
      count_d = count_q + (PTR_W+1)'(w_enq) - (PTR_W+1)'(w_deq);
      case (state_q)
         IDLE: if (w_go && !branch_mispredict) state_d = REQ;
         REQ: begin
            if (data_mem_resp) begin
               state_d = IDLE;
               drop_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      // An in-flight op survives a flush as the sole entry, marked to be dropped.
      if (branch_mispredict) begin
         if (w_in_req && !data_mem_resp) begin
            tail_d  = head_q + PTR_W'(1);
            count_d = (PTR_W+1)'(1);
            drop_d  = 1'b1;
         end else begin
            tail_d  = head_d;
            count_d = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            entry_q[i] <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         state_q   <= IDLE;
         drop_q    <= 1'b0;
         ld_done_q <= 1'b0;
         ld_tag_q  <= '0;
         ld_data_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            entry_q[i] <= entry_d[i];
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         state_q   <= state_d;
         drop_q    <= drop_d;
         ld_done_q <= w_report && !entry_q[head_q].is_store;
         if (w_report && !entry_q[head_q].is_store) begin
            ld_tag_q  <= entry_q[head_q].rob_tag;
            ld_data_q <= w_ld_data;
         end
      end
   end

   assign data_read  = w_in_req && !entry_q[head_q].is_store;
   assign data_write = w_in_req && entry_q[head_q].is_store;
   assign data_addr  = w_in_req ? {w_addr[31:2], 2'b00} : 32'h0;
   assign data_wdata = data_write ? w_wdata : 32'h0;
   assign data_mbe   = data_write ? w_mbe : 4'h0;
   assign ld_done    = ld_done_q;
   assign ld_tag     = ld_tag_q;
   assign ld_data    = ld_data_q;

`ifdef LDSTQ_PERF_EN
   logic [15:0] perf_ld_q, perf_st_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_ld_q <= 16'h0;
         perf_st_q <= 16'h0;
      end else if (w_report) begin
         if (entry_q[head_q].is_store) begin
            if (perf_st_q != 16'hFFFF) perf_st_q <= perf_st_q + 16'd1;
         end else begin
            if (perf_ld_q != 16'hFFFF) perf_ld_q <= perf_ld_q + 16'd1;
         end
      end
   end

   assign perf_loads  = perf_ld_q;
   assign perf_stores = perf_st_q;
`else
   assign perf_loads  = 16'h0;
   assign perf_stores = 16'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ldst_queue.sv
`default_nettype none
// ==========================================================================
// tb_ldst_queue : vector table plus directed sequences for ldst_queue,
//                 load results checked against a scoreboard.   Rev 1.0
// ==========================================================================
module tb_ldst_queue;
   import tomasula_types::*;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          resldst_load = 1'b0, in_is_store = 1'b0;
   logic [2:0]    in_funct3 = '0;
   logic [31:0]   in_imm = '0, in_base_data = '0, in_sd_data = '0;
   logic [2:0]    in_base_tag = '0, in_sd_tag = '0, in_rob_tag = '0;
   logic          in_base_valid = 1'b0, in_sd_valid = 1'b0;
   logic [255:0]  cdb_data = '0;
   logic [7:0]    cdb_valid = '0;
   logic          st_commit = 1'b0, branch_mispredict = 1'b0;
   logic [2:0]    st_commit_tag = '0;
   logic          data_mem_resp = 1'b0;
   logic [31:0]   data_rdata = '0;
   logic          ldst_q_full, data_read, data_write, ld_done;
   logic [31:0]   data_addr, data_wdata, ld_data;
   logic [3:0]    data_mbe;
   logic [2:0]    ld_tag;
   logic [15:0]   perf_loads, perf_stores;

   int total = 0;
   int bad   = 0;
   int exp_ld = 0;
   int exp_st = 0;

   typedef struct packed { logic [2:0] tag; logic [31:0] data; } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   typedef struct {
      bit          st;
      logic [2:0]  f3;
      logic [31:0] base, imm, sd, mem, addr, wdata, ld;
      logic [3:0]  mbe;
   } vec_t;
   vec_t vt [10];

   always #5 clk = ~clk;

   ldst_queue #(.DEPTH(4), .TAG_W(3)) dut (
      .clk(clk), .rst(rst), .resldst_load(resldst_load), .in_is_store(in_is_store),
      .in_funct3(in_funct3), .in_imm(in_imm), .in_base_tag(in_base_tag),
      .in_base_data(in_base_data), .in_base_valid(in_base_valid), .in_sd_tag(in_sd_tag),
      .in_sd_data(in_sd_data), .in_sd_valid(in_sd_valid), .in_rob_tag(in_rob_tag),
      .cdb_data(cdb_data), .cdb_valid(cdb_valid), .st_commit(st_commit),
      .st_commit_tag(st_commit_tag), .branch_mispredict(branch_mispredict),
      .ldst_q_full(ldst_q_full), .data_read(data_read), .data_write(data_write),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_mbe(data_mbe),
      .data_mem_resp(data_mem_resp), .data_rdata(data_rdata), .ld_done(ld_done),
      .ld_tag(ld_tag), .ld_data(ld_data), .perf_loads(perf_loads), .perf_stores(perf_stores)
   );

   // Scoreboard: every ld_done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && ld_done) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL ld_done_unexpected: got tag=%0d data=%h, required no result", ld_tag, ld_data);
         end else begin
            mon_e = sb.pop_front();
            if (ld_tag !== mon_e.tag || ld_data !== mon_e.data) begin
               bad++;
               $display("FAIL ld_result: got tag=%0d data=%h, required tag=%0d data=%h",
                        ld_tag, ld_data, mon_e.tag, mon_e.data);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic enq(input bit st, input logic [2:0] f3, input logic [31:0] imm,
                      input logic [2:0] btag, input logic [31:0] base, input bit bv,
                      input logic [2:0] stag, input logic [31:0] sd, input bit sv,
                      input logic [2:0] rtag);
      in_is_store = st;  in_funct3 = f3;  in_imm = imm;
      in_base_tag = btag; in_base_data = base; in_base_valid = bv;
      in_sd_tag = stag;  in_sd_data = sd;  in_sd_valid = sv;
      in_rob_tag = rtag; resldst_load = 1'b1;
      tick();
      resldst_load = 1'b0;
   endtask

   task automatic commit(input logic [2:0] t);
      st_commit = 1'b1; st_commit_tag = t;
      tick();
      st_commit = 1'b0;
   endtask

   task automatic cdb_set(input int t, input logic [31:0] v);
      cdb_valid[t] = 1'b1;
      cdb_data[t*32 +: 32] = v;
   endtask

   task automatic cdb_clear();
      cdb_valid = '0;
      cdb_data  = '0;
   endtask

   // Waits for a request, checks it and holds it lat cycles before responding.
   task automatic serve(input string nm, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] mbe, input int lat,
                        input logic [31:0] rd, input bit cnt);
      int n = 0;
      while (!(data_read || data_write) && n < 40) begin
         tick();
         n++;
      end
      total++;
      if (n >= 40) begin
         bad++;
         $display("FAIL %s_timeout: got no request, required a request within 40 cycles", nm);
         return;
      end
      chk({nm, "_wr"}, 32'(data_write), 32'(wr));
      chk({nm, "_rd"}, 32'(data_read), 32'(!wr));
      chk({nm, "_addr"}, data_addr, addr);
      if (wr) begin
         chk({nm, "_wdata"}, data_wdata, wd);
         chk({nm, "_mbe"}, 32'(data_mbe), 32'(mbe));
      end
      for (int k = 1; k < lat; k++) begin
         tick();
         chk({nm, "_hold_req"}, 32'(data_read | data_write), 32'd1);
         chk({nm, "_hold_addr"}, data_addr, addr);
      end
      data_mem_resp = 1'b1;
      data_rdata    = rd;
      tick();
      data_mem_resp = 1'b0;
      data_rdata    = '0;
      chk({nm, "_release"}, 32'(data_read | data_write), 32'd0);
      if (cnt) begin
         if (wr) exp_st++;
         else    exp_ld++;
      end
   endtask

   initial begin
      //        st f3   base          imm           sd            mem           addr          wdata         ld            mbe
      vt[0] = '{0, LB,  32'h00000200, 32'd3,        32'h0,        32'h80FFFFFF, 32'h00000200, 32'h0,        32'hFFFFFF80, 4'h0};
      vt[1] = '{0, LBU, 32'h00000200, 32'd3,        32'h0,        32'h80FFFFFF, 32'h00000200, 32'h0,        32'h00000080, 4'h0};
      vt[2] = '{0, LHU, 32'h00000200, 32'd2,        32'h0,        32'h80FFFFFF, 32'h00000200, 32'h0,        32'h000080FF, 4'h0};
      vt[3] = '{0, LH,  32'h00000200, 32'd2,        32'h0,        32'h80FF1234, 32'h00000200, 32'h0,        32'hFFFF80FF, 4'h0};
      vt[4] = '{0, LW,  32'h0FFFFFFC, 32'd8,        32'h0,        32'h12345678, 32'h10000004, 32'h0,        32'h12345678, 4'h0};
      vt[5] = '{0, LB,  32'h00000400, 32'd1,        32'h0,        32'h00007F00, 32'h00000400, 32'h0,        32'h0000007F, 4'h0};
      vt[6] = '{1, SB,  32'h00000500, 32'd3,        32'h123456CD, 32'h0,        32'h00000500, 32'hCDCDCDCD, 32'h0,        4'b1000};
      vt[7] = '{1, SH,  32'h00000500, 32'd2,        32'hFFFFBEEF, 32'h0,        32'h00000500, 32'hBEEFBEEF, 32'h0,        4'b1100};
      vt[8] = '{1, SW,  32'h00000600, 32'hFFFFFFFC, 32'hCAFEF00D, 32'h0,        32'h000005FC, 32'hCAFEF00D, 32'h0,        4'b1111};
      vt[9] = '{0, LBU, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h000000FE, 32'h00000000, 32'h0,        32'h000000FE, 4'h0};

      // Reset state
      tick(); tick();
      chk("rst_full", 32'(ldst_q_full), 32'd0);
      chk("rst_req", 32'(data_read | data_write), 32'd0);
      chk("rst_addr", data_addr, 32'd0);
      chk("rst_ld_done", 32'(ld_done), 32'd0);
      rst = 1'b0;
      tick();

      // Minimum-latency load
      enq(0, LW, 32'd4, 3'd0, 32'h100, 1, 3'd0, 32'h0, 1, 3'd5);
      chk("lat_cycle0_rd", 32'(data_read), 32'd0);
      tick();
      chk("lat_cycle1_rd", 32'(data_read), 32'd1);
      sb.push_back({3'd5, 32'hDEADBEEF});
      serve("lw_basic", 0, 32'h104, 32'h0, 4'h0, 2, 32'hDEADBEEF, 1);

      // Vector table
      for (int i = 0; i < 10; i++) begin
         enq(vt[i].st, vt[i].f3, vt[i].imm, 3'd0, vt[i].base, 1, 3'd0, vt[i].sd, 1, 3'(i));
         if (vt[i].st) begin
            tick();
            chk($sformatf("vec%0d_no_early_write", i), 32'(data_write), 32'd0);
            commit(3'(i));
         end else begin
            sb.push_back({3'(i), vt[i].ld});
         end
         serve($sformatf("vec%0d", i), vt[i].st, vt[i].addr, vt[i].wdata, vt[i].mbe,
               1 + (i % 3), vt[i].mem, 1);
      end

      // Store SB with pending base, commit after CDB
      enq(1, SB, 32'd1, 3'd2, 32'h0, 0, 3'd0, 32'h000000AB, 1, 3'd3);
      tick();
      chk("sb_wait_base", 32'(data_write), 32'd0);
      cdb_set(2, 32'h200);
      tick();
      cdb_clear();
      tick(); tick();
      chk("sb_wait_commit", 32'(data_write), 32'd0);
      commit(3'd3);
      serve("sb_cdb", 1, 32'h200, 32'hABABABAB, 4'b0010, 2, 32'h0, 1);

      // Commit arrives before both operands
      enq(1, SW, 32'd0, 3'd4, 32'h0, 0, 3'd5, 32'h0, 0, 3'd6);
      commit(3'd6);
      tick();
      chk("early_commit_wait", 32'(data_write), 32'd0);
      cdb_set(4, 32'h300);
      cdb_set(5, 32'h5555AAAA);
      tick();
      cdb_clear();
      serve("early_commit", 1, 32'h300, 32'h5555AAAA, 4'b1111, 1, 32'h0, 1);

      // Operand on the CDB in the enqueue cycle
      cdb_set(3, 32'h840);
      enq(0, LW, 32'd0, 3'd3, 32'h0, 0, 3'd0, 32'h0, 0, 3'd1);
      cdb_clear();
      sb.push_back({3'd1, 32'h0BADF00D});
      serve("enq_snoop", 0, 32'h840, 32'h0, 4'h0, 1, 32'h0BADF00D, 1);

      // Fill, overflow, drain and wrap
      for (int i = 0; i < 4; i++)
         enq(0, LW, 32'd0, 3'd1, 32'h0, 0, 3'd0, 32'h0, 0, 3'(i));
      chk("full_set", 32'(ldst_q_full), 32'd1);
      enq(0, LW, 32'd0, 3'd0, 32'h900, 1, 3'd0, 32'h0, 0, 3'd6);
      chk("full_hold", 32'(ldst_q_full), 32'd1);
      cdb_set(1, 32'h700);
      tick();
      cdb_clear();
      sb.push_back({3'd0, 32'h11111111});
      serve("full0", 0, 32'h700, 32'h0, 4'h0, 1, 32'h11111111, 1);
      chk("full_clear", 32'(ldst_q_full), 32'd0);
      enq(0, LW, 32'd0, 3'd0, 32'h800, 1, 3'd0, 32'h0, 0, 3'd7);
      sb.push_back({3'd1, 32'h22222222});
      sb.push_back({3'd2, 32'h33333333});
      sb.push_back({3'd3, 32'h44444444});
      sb.push_back({3'd7, 32'h55555555});
      serve("full1", 0, 32'h700, 32'h0, 4'h0, 2, 32'h22222222, 1);
      serve("full2", 0, 32'h700, 32'h0, 4'h0, 1, 32'h33333333, 1);
      serve("full3", 0, 32'h700, 32'h0, 4'h0, 3, 32'h44444444, 1);
      serve("wrap", 0, 32'h800, 32'h0, 4'h0, 1, 32'h55555555, 1);

      // Flush with a load in flight and two queued ops
      enq(0, LW, 32'd0, 3'd0, 32'hA00, 1, 3'd0, 32'h0, 0, 3'd2);
      enq(0, LW, 32'd4, 3'd0, 32'hA00, 1, 3'd0, 32'h0, 0, 3'd3);
      enq(1, SW, 32'd0, 3'd0, 32'hA40, 1, 3'd0, 32'h1, 1, 3'd4);
      chk("fl_req", 32'(data_read), 32'd1);
      branch_mispredict = 1'b1;
      in_is_store = 1'b0; in_base_valid = 1'b1; in_base_data = 32'hC00; in_rob_tag = 3'd6;
      resldst_load = 1'b1;
      tick();
      branch_mispredict = 1'b0;
      resldst_load = 1'b0;
      chk("fl_inflight_rd", 32'(data_read), 32'd1);
      chk("fl_inflight_addr", data_addr, 32'hA00);
      data_mem_resp = 1'b1; data_rdata = 32'h99999999;
      tick();
      data_mem_resp = 1'b0; data_rdata = '0;
      chk("fl_done_rd", 32'(data_read), 32'd0);
      commit(3'd4);
      tick(); tick();
      chk("fl_empty_req", 32'(data_read | data_write), 32'd0);
      chk("fl_empty_full", 32'(ldst_q_full), 32'd0);
      enq(0, LH, 32'd2, 3'd0, 32'hB00, 1, 3'd0, 32'h0, 0, 3'd5);
      sb.push_back({3'd5, 32'h00007FFF});
      serve("after_flush", 0, 32'hB00, 32'h0, 4'h0, 1, 32'h7FFF0000, 1);

      // Flush in IDLE empties waiting entries
      enq(0, LW, 32'd0, 3'd4, 32'h0, 0, 3'd0, 32'h0, 0, 3'd0);
      enq(0, LW, 32'd0, 3'd4, 32'h0, 0, 3'd0, 32'h0, 0, 3'd1);
      branch_mispredict = 1'b1;
      tick();
      branch_mispredict = 1'b0;
      cdb_set(4, 32'hD00);
      tick();
      cdb_clear();
      tick(); tick();
      chk("idle_flush_req", 32'(data_read), 32'd0);

`ifdef LDSTQ_PERF_EN
      chk("perf_loads", 32'(perf_loads), 32'(exp_ld));
      chk("perf_stores", 32'(perf_stores), 32'(exp_st));
`else
      chk("perf_loads_off", 32'(perf_loads), 32'd0);
      chk("perf_stores_off", 32'(perf_stores), 32'd0);
`endif

      // Reset in the middle of a request
      enq(0, LW, 32'd0, 3'd0, 32'hE00, 1, 3'd0, 32'h0, 0, 3'd2);
      tick();
      chk("mid_rst_req", 32'(data_read), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_drop", 32'(data_read), 32'd0);
      chk("mid_rst_addr", data_addr, 32'd0);
      chk("mid_rst_perf", 32'(perf_loads), 32'd0);
      tick();
      rst = 1'b0;
      tick(); tick(); tick();
      chk("post_rst_idle", 32'(data_read | data_write), 32'd0);

      tick(); tick();
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
